inv_interpolate7: RTL and testbench



---
 rtl/inv_interpolate7.sv | 170 +++++++++++++++++
 tb/tb_inv_interpolate7.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/inv_interpolate7.sv
// Inverse linear interpolator: gradient = (val - min_val) / (max_val - min_val) in Q.14, clamped to [0, 1.0].
// Latency: clamp/degenerate results 2 edges from start; divide path 16 edges (17 with INV_INTERP_ROUND_EN).
// Handshake: level start sampled in IDLE; done holds in DONE until start drops. Optional macro: INV_INTERP_ROUND_EN.
module inv_interpolate7 #(
  parameter int ITERS = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] min_val,
  input  logic [15:0] max_val,
  input  logic [15:0] val,
  output logic        busy,
  output logic        done,
  output logic        degen,
  output logic [15:0] gradient
);

`ifdef INV_INTERP_ROUND_EN
  // One extra iteration yields a guard bit used for round-half-up.
  localparam int NITER = ITERS + 1;
`else
  localparam int NITER = ITERS;
`endif
  localparam int CW = 5;

  typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_t;

  state_t          state_q, state_d;
  logic [16:0]     num_q, num_d;
  logic [16:0]     den_q, den_d;
  logic [15:0]     rem_q, rem_d;
  logic [15:0]     divisor_q, divisor_d;
  logic [NITER-1:0] q_q, q_d;
  logic [CW-1:0]   count_q, count_d;
  logic [15:0]     gradient_q, gradient_d;
  logic            degen_q, degen_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  logic [16:0]     num_abs, den_abs;
  logic [15:0]     num_mag, den_mag;
  logic [16:0]     r2;
  logic [16:0]     r2_sub;
  logic            take;
  logic [NITER-1:0] q_next;
  logic [15:0]     result;

  // Operand magnitudes and one restoring-division step, shared by PREP and DIV.
  always_comb begin
    num_abs = num_q[16] ? (~num_q + 17'd1) : num_q;
    den_abs = den_q[16] ? (~den_q + 17'd1) : den_q;
    num_mag = num_abs[15:0];
    den_mag = den_abs[15:0];
    r2      = {rem_q, 1'b0};
    r2_sub  = r2 - {1'b0, divisor_q};
    take    = (r2 >= {1'b0, divisor_q});
    q_next  = {q_q[NITER-2:0], take};
`ifdef INV_INTERP_ROUND_EN
    result  = 16'(q_next >> 1) + 16'(q_next[0]);
    if (result > 16'h4000) result = 16'h4000;
`else
    result  = 16'(q_next);
`endif
  end

  // Next-state and datapath update for the IDLE/PREP/DIV/DONE sequence.
  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    den_d      = den_q;
    rem_d      = rem_q;
    divisor_d  = divisor_q;
    q_d        = q_q;
    count_d    = count_q;
    gradient_d = gradient_q;
    degen_d    = degen_q;
    done_d     = done_q;
    busy_d     = busy_q;
    unique case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (start) begin
          // 17-bit signed differences cannot overflow for any 16-bit operands.
          num_d   = {val[15], val} - {min_val[15], min_val};
          den_d   = {max_val[15], max_val} - {min_val[15], min_val};
          busy_d  = 1'b1;
          state_d = PREP;
        end
      end
      PREP: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = DONE;
        if (den_mag == 16'd0) begin
          gradient_d = 16'h0000;
          degen_d    = 1'b1;
        end else if (num_mag == 16'd0 || num_q[16] != den_q[16]) begin
          gradient_d = 16'h0000;
          degen_d    = 1'b0;
        end else if (num_mag >= den_mag) begin
          gradient_d = 16'h4000;
          degen_d    = 1'b0;
        end else begin
          rem_d     = num_mag;
          divisor_d = den_mag;
          q_d       = '0;
          count_d   = CW'(NITER - 1);
          degen_d   = 1'b0;
          done_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = DIV;
        end
      end
      DIV: begin
        rem_d   = take ? r2_sub[15:0] : r2[15:0];
        q_d     = q_next;
        count_d = count_q - CW'(1);
        if (count_q == '0) begin
          gradient_d = result;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (!start) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything including divider state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      num_q      <= '0;
      den_q      <= '0;
      rem_q      <= '0;
      divisor_q  <= '0;
      q_q        <= '0;
      count_q    <= '0;
      gradient_q <= '0;
      degen_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      den_q      <= den_d;
      rem_q      <= rem_d;
      divisor_q  <= divisor_d;
      q_q        <= q_d;
      count_q    <= count_d;
      gradient_q <= gradient_d;
      degen_q    <= degen_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign degen    = degen_q;
  assign gradient = gradient_q;

endmodule

// File: tb/tb_inv_interpolate7.sv
module tb_inv_interpolate7;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] min_val;
  logic [15:0] max_val;
  logic [15:0] val;
  logic        busy;
  logic        done;
  logic        degen;
  logic [15:0] gradient;

  int checks = 0;
  int errors = 0;

`ifdef INV_INTERP_ROUND_EN
  localparam int DIV_EDGES = 17;
  localparam logic [15:0] G_TWO_THIRDS = 16'h2AAB;
`else
  localparam int DIV_EDGES = 16;
  localparam logic [15:0] G_TWO_THIRDS = 16'h2AAA;
`endif

  inv_interpolate7 #(.ITERS(14)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .min_val  (min_val),
    .max_val  (max_val),
    .val      (val),
    .busy     (busy),
    .done     (done),
    .degen    (degen),
    .gradient (gradient)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for done after E0 has been applied; n returns edges counted from E0.
  task automatic wait_done(input string tag, input logic scramble, output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        if (scramble) begin
          val     = 16'h5A5A;
          min_val = 16'h1234;
          max_val = 16'hC0DE;
        end
      end
      if (done) break;
    end
    if (!done) chk({tag, "_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [15:0] mn, input logic [15:0] mx,
                        input logic [15:0] v, input logic [15:0] eg, input logic ed, input int ee);
    int n;
    @(negedge clk);
    min_val = mn;
    max_val = mx;
    val     = v;
    start   = 1'b1;
    wait_done(tag, 1'b1, n);
    chk({tag, "_edges"}, 32'(n), 32'(ee));
    chk({tag, "_grad"}, 32'(gradient), 32'(eg));
    chk({tag, "_degen"}, 32'(degen), 32'(ed));
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    // Holding start keeps DONE; dropping it returns to IDLE with results held.
    @(posedge clk);
    #1;
    chk({tag, "_hold"}, 32'(done), 32'd1);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
    chk({tag, "_grad_held"}, 32'(gradient), 32'(eg));
  endtask

  initial begin
    int n;
    reset   = 1'b0;
    start   = 1'b0;
    min_val = '0;
    max_val = '0;
    val     = '0;
    #12;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_degen", 32'(degen), 32'd0);
    chk("rst_grad", 32'(gradient), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op("half",     16'h0000, 16'h0100, 16'h0080, 16'h2000, 1'b0, DIV_EDGES);
    run_op("above",    16'h0000, 16'h0100, 16'h0140, 16'h4000, 1'b0, 2);
    run_op("below",    16'h0000, 16'h0100, 16'hFF80, 16'h0000, 1'b0, 2);
    run_op("reversed", 16'h0100, 16'h0000, 16'h0040, 16'h3000, 1'b0, DIV_EDGES);
    run_op("third",    16'h0000, 16'h0180, 16'h0100, G_TWO_THIRDS, 1'b0, DIV_EDGES);
    run_op("degen",    16'h0200, 16'h0200, 16'h0300, 16'h0000, 1'b1, 2);
    run_op("at_min",   16'h0040, 16'h0100, 16'h0040, 16'h0000, 1'b0, 2);
    run_op("at_max",   16'h0040, 16'h0100, 16'h0100, 16'h4000, 1'b0, 2);
    // 32768/65535 of full scale: floor gives 0x2000 in both builds.
    run_op("extreme",  16'h8000, 16'h7FFF, 16'h0000, 16'h2000, 1'b0, DIV_EDGES);

    // Reset during DIV iteration 7: E0, E1, then E2..E8.
    @(negedge clk);
    min_val = 16'h0000;
    max_val = 16'h0100;
    val     = 16'h0040;
    start   = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_grad_prev", 32'(gradient), 32'h2000);
    reset = 1'b0;
    #1;
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_grad", 32'(gradient), 32'h0000);
    @(negedge clk);
    min_val = 16'h0000;
    max_val = 16'h0180;
    val     = 16'h0100;
    reset   = 1'b1;
    wait_done("post_rst", 1'b0, n);
    chk("post_rst_edges", 32'(n), 32'(DIV_EDGES));
    chk("post_rst_grad", 32'(gradient), 32'(G_TWO_THIRDS));
    chk("post_rst_degen", 32'(degen), 32'd0);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_done_clr", 32'(done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
